// File: rtl/alarm_beeper.sv
// alarm_beeper: Wishbone-controlled gate that passes a PWM tone to a buzzer
// in timed on/off beep bursts, with completion interrupt.
module alarm_beeper #(
    parameter int CW = 16,
    parameter int NW = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_inta_o,
    input  logic        pwm_i,
    output logic        buzzer_o
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t state;
    logic en, cont, inte, irq;
    logic [CW-1:0] on_time, off_time, cnt;
    logic [NW-1:0] count, rem;
    logic [1:0] sync;
    logic req, wr, last, beep_end, unused;

    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr = req & wb_we_i;
    assign wb_err_o = 1'b0;
    assign wb_inta_o = irq & inte;
    assign unused = ^{wb_adr_i, wb_dat_i};
    assign last = cnt <= CW'(1);
    // a beep ends after its OFF phase, or straight after ON when OFF_TIME is zero
    assign beep_end = last && (state == OFF || (state == ON && off_time == '0));

    always_comb
        wb_dat_o = wb_adr_i[3:2] == 2'd0 ? {27'd0, state != IDLE, irq, inte, cont, en} :
                   wb_adr_i[3:2] == 2'd1 ? 32'(on_time) :
                   wb_adr_i[3:2] == 2'd2 ? 32'(off_time) :
                   32'(state == IDLE ? count : rem);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            sync <= '0;
            wb_ack_o <= 1'b0;
        end else begin
            sync <= {sync[0], pwm_i};
            wb_ack_o <= req;
        end

    // FSM assignments follow the bus write so an interrupt set beats a same-cycle clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state <= IDLE;
            en <= 1'b0;
            cont <= 1'b0;
            inte <= 1'b0;
            irq <= 1'b0;
            on_time <= '0;
            off_time <= '0;
            count <= '0;
            cnt <= '0;
            rem <= '0;
            buzzer_o <= 1'b0;
        end else begin
            if (wr)
                case (wb_adr_i[3:2])
                    2'd0: begin
                        en <= wb_dat_i[0];
                        cont <= wb_dat_i[1];
                        inte <= wb_dat_i[2];
                        if (wb_dat_i[3]) irq <= 1'b0;
                    end
                    2'd1: on_time <= wb_dat_i[CW-1:0];
                    2'd2: off_time <= wb_dat_i[CW-1:0];
                    default: count <= wb_dat_i[NW-1:0];
                endcase
            buzzer_o <= 1'b0;
            if (state != IDLE && !en)
                state <= IDLE;
            else if (beep_end) begin
                if (rem > NW'(1) || cont) begin
                    state <= ON;
                    cnt <= on_time;
                    rem <= rem > NW'(1) ? rem - 1'b1 : count;
                    buzzer_o <= sync[1];
                end else begin
                    state <= IDLE;
                    en <= 1'b0;
                    irq <= 1'b1;
                end
            end else if (state == ON && last) begin
                state <= OFF;
                cnt <= off_time;
            end else if (state != IDLE) begin
                cnt <= cnt - 1'b1;
                buzzer_o <= state == ON ? sync[1] : 1'b0;
            end else if (en && on_time != '0 && count != '0) begin
                state <= ON;
                cnt <= on_time;
                rem <= count;
                buzzer_o <= sync[1];
            end else if (en) begin
                en <= 1'b0;
                irq <= 1'b1;
            end
        end
endmodule

// File: tb/tb_alarm_beeper.sv
// tb_alarm_beeper: directed and randomized bursts checked against an
// arithmetic timeline model of the beep pattern.
module tb_alarm_beeper;
    logic wb_clk_i = 1'b0;
    logic wb_rst_i, wb_cyc_i, wb_stb_i, wb_we_i, pwm_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic wb_ack_o, wb_err_o, wb_inta_o, buzzer_o;
    int tests = 0;
    int fails = 0;

    alarm_beeper dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_inta_o(wb_inta_o),
        .pwm_i(pwm_i), .buzzer_o(buzzer_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i = we;
        wb_adr_i = {28'd0, a};
        wb_dat_i = d;
        @(posedge wb_clk_i);
        #1;
        check("ack", 32'(wb_ack_o), 1);
        check("err", 32'(wb_err_o), 0);
        q = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check("ack_drop", 32'(wb_ack_o), 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] q);
        bus(1'b0, a, 32'd0, q);
    endtask

    // t counts cycles from the first ON edge; buzzer carries the tone from 3 edges back
    task automatic burst(input int on, input int off, input int cnt, input logic cont,
                         input logic rnd, input int len);
        logic h[0:63];
        logic v0, e;
        int p;
        v0 = pwm_i;
        p = on + off;
        wr(4'h4, on);
        wr(4'h8, off);
        wr(4'hC, cnt);
        wr(4'h0, cont ? 32'h7 : 32'h5);
        for (int t = 1; t <= len; t++) begin
            @(posedge wb_clk_i);
            #1;
            e = ((cont || t < cnt * p) && (t % p) < on) ? (t < 4 ? v0 : h[t-3]) : 1'b0;
            check("buzzer", 32'(buzzer_o), 32'(e));
            h[t] = rnd ? 1'($urandom) : v0;
            pwm_i = h[t];
        end
    endtask

    initial begin
        logic [31:0] q;
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        pwm_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_buzzer", 32'(buzzer_o), 0);
        check("rst_ack", 32'(wb_ack_o), 0);
        check("rst_inta", 32'(wb_inta_o), 0);
        check("rst_ctrl", wb_dat_o, 0);
        wb_rst_i = 1'b0;

        pwm_i = 1'b1;
        burst(4, 3, 2, 1'b0, 1'b0, 16);
        rd(4'h0, q);
        check("ctrl_done", q, 32'h0C);
        check("inta_done", 32'(wb_inta_o), 1);
        rd(4'hC, q);
        check("count_idle", q, 2);
        wr(4'h0, 32'h8);
        rd(4'h0, q);
        check("ctrl_w1c", q, 0);
        check("inta_w1c", 32'(wb_inta_o), 0);

        burst(2, 0, 3, 1'b0, 1'b0, 8);
        rd(4'h0, q);
        check("ctrl_nooff", q, 32'h0C);
        wr(4'h0, 32'h8);

        burst(3, 2, 1, 1'b1, 1'b0, 20);
        wr(4'h0, 32'h2);
        check("buzzer_stop", 32'(buzzer_o), 0);
        rd(4'h0, q);
        check("ctrl_stop", q, 32'h02);
        check("inta_stop", 32'(wb_inta_o), 0);

        wr(4'hC, 0);
        wr(4'h4, 3);
        wr(4'h0, 32'h1);
        check("buzzer_cnt0", 32'(buzzer_o), 0);
        rd(4'h0, q);
        check("ctrl_cnt0", q, 32'h08);
        wr(4'h0, 32'h8);

        for (int i = 0; i < 6; i++) begin
            int on_t, off_t, n_t;
            on_t = int'($urandom_range(1, 5));
            off_t = int'($urandom_range(0, 4));
            n_t = int'($urandom_range(1, 4));
            pwm_i = 1'($urandom);
            burst(on_t, off_t, n_t, 1'b0, 1'b1, n_t * (on_t + off_t) + 3);
            rd(4'h0, q);
            check("ctrl_rand", q, 32'h0C);
            wr(4'h0, 32'h8);
        end

        wr(4'h4, 1);
        wr(4'h8, 0);
        wr(4'hC, 1);
        wr(4'h0, 32'h1);
        wr(4'h0, 32'h8);
        rd(4'h0, q);
        check("int_set_wins", q, 32'h08);
        wr(4'h0, 32'h8);
        rd(4'h0, q);
        check("int_cleared", q, 0);

        pwm_i = 1'b1;
        wr(4'h4, 6);
        wr(4'h8, 0);
        wr(4'hC, 3);
        wr(4'h0, 32'h1);
        rd(4'hC, q);
        check("count_busy", q, 3);
        rd(4'h0, q);
        check("ctrl_busy", q, 32'h11);
        check("buzzer_on", 32'(buzzer_o), 1);
        wb_rst_i = 1'b1;
        #1;
        check("rst_mid_buzzer", 32'(buzzer_o), 0);
        check("rst_mid_inta", 32'(wb_inta_o), 0);
        for (int a = 0; a < 4; a++) begin
            wb_adr_i = 32'(a * 4);
            #1;
            check("rst_mid_reg", wb_dat_o, 0);
        end
        wb_rst_i = 1'b0;
        rd(4'h0, q);
        check("ctrl_after_rst", q, 0);
        check("buzzer_after_rst", 32'(buzzer_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alarm_beeper.md
ALARM_BEEPER -- requirements
Module: alarm_beeper

Interface
REQ-001 Parameter CW, default 16, width of ON_TIME/OFF_TIME cycle counters.
REQ-002 Parameter NW, default 8, width of beep-count register.
REQ-003 wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 wb_cyc_i / wb_stb_i / wb_we_i  input  1 each  Wishbone classic slave cycle, strobe, write enable.
REQ-006 wb_adr_i  input  32  byte address; only bits [3:2] decoded.
REQ-007 wb_dat_i  input  32  write data; wb_dat_o  output  32  read data.
REQ-008 wb_ack_o  output  1  transfer acknowledge; wb_err_o  output  1  tied 0.
REQ-009 wb_inta_o  output  1  interrupt, level, = CTRL.INT & CTRL.INTE.
REQ-010 pwm_i  input  1  tone from the PTC timer PWM output, asynchronous to nothing but treated as untimed.
REQ-011 buzzer_o  output  1  gated tone to alarm buzzer.

Function
REQ-012 Register map: 0x0 CTRL, 0x4 ON_TIME[CW-1:0], 0x8 OFF_TIME[CW-1:0], 0xC COUNT[NW-1:0]; unused read bits return 0.
REQ-013 CTRL bits: [0] EN rw, [1] CONT rw, [2] INTE rw, [3] INT write-1-to-clear, [4] BUSY read-only (state != IDLE).
REQ-014 COUNT write loads beep total; COUNT read returns remaining beeps of current burst (total when IDLE).
REQ-015 wb_ack_o asserted exactly one cycle, registered, the cycle after cyc&stb seen with ack low; deasserted next cycle; write takes effect on the ack cycle edge.
REQ-016 pwm_i passes a 2-flop synchronizer; buzzer_o is registered: buzzer_o = synced pwm in ON, else 0 (3-cycle pwm_i-to-buzzer_o latency).
REQ-017 FSM states IDLE, ON, OFF.
REQ-018 IDLE -> ON when EN=1, ON_TIME!=0, COUNT!=0; loads phase counter with ON_TIME, remaining with COUNT.
REQ-019 EN=1 with ON_TIME=0 or COUNT=0: stay IDLE, EN auto-cleared, INT set.
REQ-020 ON lasts exactly ON_TIME cycles, then -> OFF loading OFF_TIME; if OFF_TIME=0, OFF is skipped (next ON or IDLE directly).
REQ-021 OFF lasts exactly OFF_TIME cycles; at end remaining decrements.
REQ-022 After decrement to 0: CONT=0 -> IDLE, EN cleared, INT set; CONT=1 -> remaining reloads COUNT, -> ON, no INT.
REQ-023 ON_TIME/OFF_TIME/COUNT writes while BUSY take effect at next phase/burst load, never mid-phase.
REQ-024 EN written 0 while BUSY: -> IDLE next edge, buzzer_o 0 that edge, INT not set.
REQ-025 INT set and W1C in same cycle: set wins.
REQ-026 Counters never wrap; max ON_TIME/OFF_TIME = 2^CW-1 cycles.

Reset
REQ-027 On wb_rst_i high, immediately: state IDLE, all registers 0, wb_ack_o 0, wb_inta_o 0, buzzer_o 0, synchronizer flops 0.
REQ-028 Reset mid-burst aborts with no INT; after deassert first transfer acks normally.

Verification
REQ-029 Write ON=4, OFF=3, COUNT=2, CTRL=0x5, pwm_i=1 -> buzzer_o high 4 cycles, low 3, high 4, low; INT=1, wb_inta_o=1, EN=0, BUSY=0.
REQ-030 Write CTRL=0x8 after REQ-029 -> INT=0, wb_inta_o=0; single-cycle ack each access, wb_err_o always 0.
REQ-031 ON=2, OFF=0, COUNT=3 -> buzzer_o enabled 6 consecutive cycles, then IDLE with INT.
REQ-032 CONT=1, ON=3, OFF=2, COUNT=1 -> 3-on/2-off repeats indefinitely; write EN=0 -> buzzer_o 0, BUSY 0 next cycle, INT stays 0.
REQ-033 EN=1 with COUNT=0 -> no ON cycle, INT=1, EN reads 0.
REQ-034 Toggle pwm_i every cycle during ON -> buzzer_o follows delayed 3 cycles; assert wb_rst_i mid-ON -> buzzer_o, BUSY, all regs 0 immediately.
